row_col_dec: RTL and testbench

Inverse of the DCO row/column capacitor-bank selector. Takes the registered `r_all`/`row`/`col` select vectors that drive the bank and reconstructs the binary tuning word, `word = {R, C}`. It also checks that the select pattern is legal and keeps error statistics. It sits beside the DCO model as a bank-state monitor, feeding the ADPLL testbench and the debug register file.

---
 rtl/row_col_pkg.sv | 34 +++
 rtl/row_col_dec_therm_chk.sv | 29 ++
 rtl/row_col_dec.sv | 111 +++++++++++
 tb/tb_row_col_dec.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/row_col_pkg.sv
// Shared constants and helpers for the DCO row/column capacitor-bank encoder and decoder.
package row_col_pkg;

  localparam int ROW_W_DEF = 4;
  localparam int SIZE_DEF  = 1 << ROW_W_DEF;
  localparam int WORD_W_DEF = 2 * ROW_W_DEF;

  localparam int ERR_THERM = 0;
  localparam int ERR_ROW   = 1;
  localparam int ERR_COL   = 2;

  // Bank midpoint: half the rows fully on, no partial column.
  localparam logic [WORD_W_DEF-1:0] RST_WORD = WORD_W_DEF'((SIZE_DEF / 2) << ROW_W_DEF);

  // Index of the lowest set bit among the low n bits; n when none is set.
  function automatic int tz_count(input logic [63:0] v, input int n);
    int r;
    r = n;
    for (int i = 63; i >= 0; i--) begin
      if (i < n && v[i]) r = i;
    end
    return r;
  endfunction

  function automatic int popcount(input logic [63:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/row_col_dec_therm_chk.sv
// Thermometer check: counts ones and flags whether they form a contiguous run
// anchored at the LSB (dir=0) or at the MSB (dir=1).
module therm_chk
  import row_col_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int CNT_W = 5
) (
  input  logic [SIZE-1:0]  vec,
  input  logic             dir,
  output logic [CNT_W-1:0] cnt,
  output logic             legal
);

  logic [SIZE-1:0] lo_mask;
  logic [SIZE-1:0] hi_mask;

  always_comb begin
    cnt     = CNT_W'(popcount(64'(vec)));
    lo_mask = '0;
    hi_mask = '0;
    for (int i = 0; i < SIZE; i++) begin
      lo_mask[i] = (i < int'(cnt));
      hi_mask[i] = (i >= SIZE - int'(cnt));
    end
    legal = (vec == (dir ? hi_mask : lo_mask));
  end

endmodule

// File: rtl/row_col_dec.sv
// Capacitor-bank monitor: rebuilds the tuning word {R, C} from the registered
// r_all/row/col selects, flags illegal patterns and keeps error statistics.
module row_col_dec
  import row_col_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int ROW_W  = 4,
  parameter int SIZE   = 1 << ROW_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [SIZE-1:0]   r_all,
  input  logic [SIZE-1:0]   row,
  input  logic [SIZE-1:0]   col,
  input  logic              clr,
  output logic [WORD_W-1:0] word,
  output logic              vld,
  output logic [2:0]        err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [WORD_W-1:0] RST_W = WORD_W'((SIZE / 2) << ROW_W);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [SIZE-1:0]   r_all_p0;
  logic [SIZE-1:0]   row_p0;
  logic [SIZE-1:0]   col_p0;
  logic              vld_p0;

  logic [ROW_W:0]    rall_cnt;
  logic              rall_legal;
  logic [ROW_W:0]    c_cnt;
  logic              col_legal;
  logic [ROW_W-1:0]  r_idx;
  logic [2:0]        err_next;
  logic [WORD_W-1:0] word_next;
  int                tz;

  // Stage 0: capture the bank selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      r_all_p0 <= '0;
      row_p0   <= '0;
      col_p0   <= '0;
    end else begin
      vld_p0 <= en;
      if (en) begin
        r_all_p0 <= r_all;
        row_p0   <= row;
        col_p0   <= col;
      end
    end
  end

  therm_chk #(.SIZE(SIZE), .CNT_W(ROW_W + 1)) u_rall_chk (
    .vec   (~r_all_p0),
    .dir   (1'b0),
    .cnt   (rall_cnt),
    .legal (rall_legal)
  );

  // Column fill direction alternates with row parity (serpentine bank layout).
  therm_chk #(.SIZE(SIZE), .CNT_W(ROW_W + 1)) u_col_chk (
    .vec   (col_p0),
    .dir   (r_idx[0]),
    .cnt   (c_cnt),
    .legal (col_legal)
  );

  always_comb begin
    tz    = tz_count(64'(r_all_p0), SIZE);
    r_idx = (tz >= SIZE) ? ROW_W'(SIZE - 1) : ROW_W'(tz);
    err_next            = '0;
    err_next[ERR_THERM] = ~rall_legal | rall_cnt[ROW_W];
    err_next[ERR_ROW]   = (row_p0 != (SIZE'(1) << r_idx));
    err_next[ERR_COL]   = c_cnt[ROW_W] | ~col_legal;
    word_next           = WORD_W'({r_idx, c_cnt[ROW_W-1:0]});
  end

  // Stage 1: decoded outputs and error statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld        <= 1'b0;
      word       <= RST_W;
      err        <= '0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      vld <= vld_p0;
      if (vld_p0) begin
        word <= word_next;
        err  <= err_next;
      end
      if (clr) begin
        err_sticky <= 1'b0;
        err_cnt    <= '0;
      end else if (vld_p0 && err_next != 3'b000) begin
        err_sticky <= 1'b1;
        err_cnt    <= sat_inc(err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_row_col_dec.sv
// Scoreboard bench for row_col_dec: directed samples push expectations, a
// monitor pops and compares on every vld.
module tb_row_col_dec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] r_all = 16'hFFFF;
  logic [15:0] row = 16'h0001;
  logic [15:0] col = 16'h0000;
  logic [7:0]  word;
  logic        vld;
  logic [2:0]  err;
  logic        err_sticky;
  logic [7:0]  err_cnt;

  typedef struct {
    logic [7:0] w;
    logic [2:0] e;
    logic [7:0] cnt;
    logic       st;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   mcnt = 0;
  bit   mst = 1'b0;
  bit   pend = 1'b0;

  row_col_dec #(.WORD_W(8), .ROW_W(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .r_all      (r_all),
    .row        (row),
    .col        (col),
    .clr        (clr),
    .word       (word),
    .vld        (vld),
    .err        (err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // fl: assert clr on the edge where this sample's result appears
  task automatic send(input logic [15:0] r, input logic [15:0] rw, input logic [15:0] c,
                      input logic [7:0] w, input logic [2:0] e, input bit fl);
    exp_t x;
    @(negedge clk);
    en = 1'b1; r_all = r; row = rw; col = c;
    clr = pend; pend = fl;
    if (fl) begin
      mcnt = 0; mst = 1'b0;
    end else if (e != 3'b000) begin
      if (mcnt < 255) mcnt++;
      mst = 1'b1;
    end
    x.w = w; x.e = e; x.cnt = 8'(mcnt); x.st = mst;
    q.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0;
    clr = pend; pend = 1'b0;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst_n && vld) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_vld: got word %0h with no pending sample", word);
        end else begin
          x = q.pop_front();
          chk("word", 32'(word), 32'(x.w));
          chk("err", 32'(err), 32'(x.e));
          chk("err_cnt", 32'(err_cnt), 32'(x.cnt));
          chk("err_sticky", 32'(err_sticky), 32'(x.st));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] r, rw, c;
    int k, cc, waitc;

    // 1: reset, then idle
    #1 rst_n = 1'b0;
    #2;
    chk("rst_word", 32'(word), 32'h80);
    chk("rst_vld", 32'(vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    chk("idle_word", 32'(word), 32'h80);
    chk("idle_vld", 32'(vld), 32'h0);
    chk("idle_err", 32'(err), 32'h0);
    chk("idle_cnt", 32'(err_cnt), 32'h0);
    chk("idle_sticky", 32'(err_sticky), 32'h0);

    // 2: legal even rows
    send(16'hFFFF, 16'h0001, 16'h0000, 8'h00, 3'b000, 0);
    send(16'hFFFC, 16'h0004, 16'h0007, 8'h23, 3'b000, 0);
    // 3: odd row, columns from the top; then wrong side
    send(16'hFFFE, 16'h0002, 16'hF800, 8'h15, 3'b000, 0);
    send(16'hFFFE, 16'h0002, 16'h001F, 8'h15, 3'b100, 0);
    // 4: illegal patterns back-to-back
    send(16'hFFFF, 16'h0006, 16'h0000, 8'h00, 3'b010, 0);
    send(16'hFF0F, 16'h0001, 16'h0000, 8'h00, 3'b001, 0);
    send(16'hFFFF, 16'h0001, 16'h0005, 8'h02, 3'b100, 0);
    // boundaries: r_all all zeros clamps R to 15; full column row truncates C
    send(16'h0000, 16'h8000, 16'h0000, 8'hF0, 3'b001, 0);
    send(16'hFFFF, 16'h0001, 16'hFFFF, 8'h00, 3'b100, 0);
    idle();
    idle();

    // 5: saturate the counter, then clear on an erroring sample
    for (int i = 0; i < 300; i++)
      send(16'hFFFF, 16'h0006, 16'h0000, 8'h00, 3'b010, 0);
    send(16'hFFFF, 16'h0006, 16'h0000, 8'h00, 3'b010, 1);
    send(16'hFFFC, 16'h0004, 16'h0003, 8'h22, 3'b000, 0);
    idle();
    idle();
    idle();

    // 6: stream of legal words with a reset between samples 8 and 9
    for (int i = 0; i < 16; i++) begin
      k  = i % 16;
      cc = (i * 3 + 1) % 16;
      r  = 16'hFFFF << k;
      rw = 16'h0001 << k;
      c  = (k % 2 == 0) ? ((16'h0001 << cc) - 16'h0001) : ~(16'hFFFF >> cc);
      send(r, rw, c, {4'(k), 4'(cc)}, 3'b000, 0);
      if (i == 7) begin
        idle();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_word", 32'(word), 32'h80);
        chk("midrst_vld", 32'(vld), 32'h0);
        chk("midrst_err", 32'(err), 32'h0);
        chk("midrst_cnt", 32'(err_cnt), 32'h0);
        chk("midrst_sticky", 32'(err_sticky), 32'h0);
        mcnt = 0; mst = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("post_rst_vld", 32'(vld), 32'h0);
      end
    end
    idle();
    idle();

    waitc = 0;
    while (q.size() != 0 && waitc < 50) begin
      idle();
      waitc++;
    end
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
